// File: rtl/img_sender_pkg.sv
// img_sender_pkg: UART register map, status bits and sender state encoding
package img_sender_pkg;
  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;
  localparam int         TX_OK_BIT   = 6;
  localparam int         RX_OK_BIT   = 7;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_POLL, S_SEND, S_DONE} state_t;
endpackage

// File: rtl/img_sender.sv
// img_sender: streams a frame buffer out of an Avalon-MM UART, two bytes per pixel, high byte first
module img_sender
  import img_sender_pkg::*;
#(
  parameter int HEIGHT = 480,
  parameter int WIDTH  = 800
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic        i_start,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic [19:0] o_address,
  input  logic [15:0] i_data,
  output logic        o_busy,
  output logic        o_fin
);
  localparam logic [19:0] LAST = 20'(HEIGHT * WIDTH - 1);
  state_t      state;
  logic [15:0] pixel;
  logic        byte_sel;
  logic        unused_status;
  assign unused_status = ^{avm_readdata[31:TX_OK_BIT+1], avm_readdata[TX_OK_BIT-1:0]};
  assign o_busy = state != S_IDLE;
  // Frame sequencer; bus outputs are set on each transition so they always describe the state being entered
  always_ff @(posedge avm_clk or posedge avm_rst)
    if (avm_rst) begin
      state         <= S_IDLE;
      avm_address   <= STATUS_BASE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      o_address     <= '0;
      pixel         <= '0;
      byte_sel      <= 1'b0;
      o_fin         <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (i_start) begin
            o_address <= '0;
            state     <= S_FETCH;
          end
        S_FETCH: begin
          pixel       <= i_data;
          byte_sel    <= 1'b0;
          avm_address <= STATUS_BASE;
          avm_read    <= 1'b1;
          state       <= S_POLL;
        end
        S_POLL:
          if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= TX_BASE;
            avm_writedata <= {24'b0, byte_sel ? pixel[7:0] : pixel[15:8]};
            state         <= S_SEND;
          end
        S_SEND:
          if (!avm_waitrequest) begin
            avm_write   <= 1'b0;
            avm_address <= STATUS_BASE;
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              avm_read <= 1'b1;
              state    <= S_POLL;
            end else if (o_address == LAST) begin
              o_fin <= 1'b1;
              state <= S_DONE;
            end else begin
              o_address <= o_address + 20'd1;
              state     <= S_FETCH;
            end
          end
        S_DONE: begin
          o_fin <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_img_sender.sv
// tb_img_sender: directed checks of img_sender on a 2x2 frame
module tb_img_sender;
  logic        avm_clk = 1'b0;
  logic        avm_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = 32'h40;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [19:0] o_address;
  logic [15:0] i_data;
  logic        o_busy;
  logic        o_fin;
  logic [15:0] mem [4] = '{16'h1234, 16'hABCD, 16'h00FF, 16'h8001};
  logic [7:0]  exp_b [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'h80, 8'h01};
  logic [7:0]  bytes [$];
  int          fins = 0;
  int          rw_both = 0;
  int          checks = 0;
  int          errors = 0;
  int          f0;
  logic [31:0] d0;

  img_sender #(.HEIGHT(2), .WIDTH(2)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .i_start(i_start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .o_address(o_address), .i_data(i_data), .o_busy(o_busy), .o_fin(o_fin)
  );

  always #5 avm_clk = ~avm_clk;
  assign i_data = mem[o_address[1:0]];

  always @(negedge avm_clk)
    if (!avm_rst) begin
      if (avm_write && !avm_waitrequest) bytes.push_back(avm_writedata[7:0]);
      if (o_fin) fins++;
      if (avm_read && avm_write) rw_both++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, 32'(avm_address), 32'd8);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_write"}, 32'(avm_write), 32'd0);
    chk({tag, "_wdata"}, avm_writedata, 32'd0);
    chk({tag, "_oaddr"}, 32'(o_address), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_fin"}, 32'(o_fin), 32'd0);
  endtask

  task automatic start_frame();
    @(posedge avm_clk); #1 i_start = 1'b1;
    @(posedge avm_clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (o_busy && k < 1000) begin
      @(negedge avm_clk);
      k++;
    end
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (bytes.size() < n && k < 500) begin
      @(negedge avm_clk);
      k++;
    end
    chk("wait_bytes", 32'(bytes.size() >= n), 32'd1);
  endtask

  task automatic wait_read();
    int k = 0;
    @(negedge avm_clk);
    while (!avm_read && k < 500) begin
      @(negedge avm_clk);
      k++;
    end
    chk("wait_read", 32'(avm_read), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 32'(bytes.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < bytes.size()) chk($sformatf("%s_b%0d", tag, i), 32'(bytes[i]), 32'(exp_b[i]));
    chk({tag, "_fins"}, 32'(fins - f0), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge avm_clk);
    #1 chk_reset("rst");
    avm_rst = 1'b0;

    bytes.delete(); f0 = fins;
    start_frame();
    wait_idle("f1");
    check_seq("f1");
    chk("f1_last_addr", 32'(o_address), 32'd3);

    bytes.delete(); f0 = fins;
    avm_readdata = 32'h0;
    start_frame();
    repeat (10) @(negedge avm_clk);
    chk("hold_nowrite", 32'(bytes.size()), 32'd0);
    chk("hold_read", 32'(avm_read), 32'd1);
    @(posedge avm_clk); #1 avm_readdata = 32'h40;
    @(negedge avm_clk);
    chk("hold_lastpoll_write", 32'(avm_write), 32'd0);
    @(negedge avm_clk);
    chk("hold_first_write", 32'(avm_write), 32'd1);
    chk("hold_first_addr", 32'(avm_address), 32'd4);
    wait_idle("hold");
    check_seq("hold");

    bytes.delete(); f0 = fins;
    start_frame();
    wait_read();
    @(posedge avm_clk); #1 avm_waitrequest = 1'b1;
    @(negedge avm_clk);
    d0 = avm_writedata;
    chk("stall_data", d0, 32'h12);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge avm_clk);
      chk($sformatf("stall%0d_write", i), 32'(avm_write), 32'd1);
      chk($sformatf("stall%0d_addr", i), 32'(avm_address), 32'd4);
      chk($sformatf("stall%0d_data", i), avm_writedata, d0);
    end
    @(posedge avm_clk); #1 avm_waitrequest = 1'b0;
    wait_idle("stall");
    check_seq("stall");

    bytes.delete(); f0 = fins;
    start_frame();
    wait_bytes(2);
    start_frame();
    wait_idle("mid");
    check_seq("mid");
    repeat (5) @(negedge avm_clk);
    chk("mid_no_requeue", 32'(o_busy), 32'd0);

    bytes.delete(); f0 = fins;
    start_frame();
    wait_bytes(3);
    @(posedge avm_clk); #1 avm_rst = 1'b1;
    #1 chk_reset("midrst");
    bytes.delete();
    repeat (2) @(posedge avm_clk);
    #1 avm_rst = 1'b0;
    repeat (5) @(negedge avm_clk);
    chk("midrst_nowrite", 32'(bytes.size()), 32'd0);
    f0 = fins;
    start_frame();
    wait_idle("restart");
    check_seq("restart");

    bytes.delete(); f0 = fins;
    avm_readdata = 32'h80;
    start_frame();
    repeat (20) @(negedge avm_clk);
    chk("rx_only_nowrite", 32'(bytes.size()), 32'd0);
    chk("rx_only_read", 32'(avm_read), 32'd1);
    chk("rx_only_busy", 32'(o_busy), 32'd1);
    @(posedge avm_clk); #1 avm_readdata = 32'hC0;
    wait_idle("rx_only");
    check_seq("rx_only");

    chk("read_write_overlap", 32'(rw_both), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/img_sender.md
IMG_SENDER -- requirements
Module: img_sender

Interface
REQ-001 SHALL have parameter HEIGHT, default 480, image rows.
REQ-002 SHALL have parameter WIDTH, default 800, image columns; HEIGHT*WIDTH SHALL NOT exceed 2^20.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all state SHALL be clocked on posedge avm_clk and cleared on posedge avm_rst.
REQ-004 avm_clk  input  1  system clock.
REQ-005 avm_rst  input  1  asynchronous active-high reset.
REQ-006 i_start  input  1  single-cycle request to send one frame; sampled only in S_IDLE.
REQ-007 avm_address  output  5  UART register byte offset: RX=0, TX=4, STATUS=8.
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_readdata  input  32  UART register read data; bit 6 = TX space available.
REQ-010 avm_write  output  1  Avalon-MM write strobe.
REQ-011 avm_writedata  output  32  {24'b0, byte to transmit}.
REQ-012 avm_waitrequest  input  1  slave stall; a transfer completes in the cycle it is low.
REQ-013 o_address  output  20  frame-buffer pixel address, registered.
REQ-014 i_data  input  16  frame-buffer pixel, valid one cycle after o_address changes.
REQ-015 o_busy  output  1  high in every state except S_IDLE.
REQ-016 o_fin  output  1  one-cycle pulse when the last byte of the frame is accepted.

Function
REQ-017 States SHALL be S_IDLE, S_FETCH, S_POLL, S_SEND, S_DONE.
REQ-018 S_IDLE: avm_address=8, avm_read=0, avm_write=0; on i_start, o_address<=0, next S_FETCH.
REQ-019 S_FETCH lasts exactly one cycle: latch i_data into the pixel register, clear byte_sel, next S_POLL.
REQ-020 S_POLL: avm_address=8, avm_read=1, avm_write=0; when !avm_waitrequest && avm_readdata[6], next S_SEND; otherwise remain in S_POLL.
REQ-021 Bit 7 (RX ready) SHALL be ignored.
REQ-022 S_SEND: avm_address=4, avm_read=0, avm_write=1, avm_writedata = {24'b0, byte_sel ? pixel[7:0] : pixel[15:8]}.
REQ-023 While avm_waitrequest is high in S_SEND, address, strobes and writedata SHALL be held stable.
REQ-024 On S_SEND completion with byte_sel=0: set byte_sel=1, next S_POLL.
REQ-025 On S_SEND completion with byte_sel=1: if o_address == HEIGHT*WIDTH-1, next S_DONE; else o_address+1, next S_FETCH.
REQ-026 S_DONE: o_fin=1 for exactly one cycle, strobes low, next S_IDLE.
REQ-027 Exactly 2*HEIGHT*WIDTH TX writes SHALL occur per frame, high byte first, in ascending address order.
REQ-028 i_start asserted outside S_IDLE SHALL be ignored and SHALL NOT restart or queue a frame.
REQ-029 avm_read and avm_write SHALL never be high in the same cycle.
REQ-030 The o_address increment SHALL NOT wrap within a frame; the final address SHALL be HEIGHT*WIDTH-1.

Reset
REQ-031 Reset values: state=S_IDLE, avm_address=8, avm_read=0, avm_write=0, avm_writedata=0, o_address=0, pixel=0, byte_sel=0, o_busy=0, o_fin=0.
REQ-032 Reset mid-frame SHALL abort immediately with no further writes; the next i_start SHALL restart at address 0.

Structure
REQ-033 A shared package SHALL hold RX_BASE, TX_BASE, STATUS_BASE, TX_OK_BIT, RX_OK_BIT and the state enum, for use by both the sender and the loader.
REQ-034 The block SHALL be a single module with no sub-modules.

Verification
REQ-035 HEIGHT=2, WIDTH=2, pixels 0x1234/0xABCD/0x00FF/0x8001, status bit 6 always 1, no stalls -> writedata bytes 12,34,AB,CD,00,FF,80,01; one o_fin pulse; o_busy low afterwards.
REQ-036 Status bit 6 held at 0 for 10 polls -> no avm_write during those polls; the first write occurs the cycle after bit 6=1 is read with waitrequest low.
REQ-037 waitrequest held high for 3 cycles during a TX write -> address=4 and writedata held stable; the byte is counted once and the total stays at 8 writes.
REQ-038 i_start pulsed mid-frame -> byte sequence unchanged; exactly one o_fin.
REQ-039 Reset asserted after the 3rd write -> all outputs at reset values within the reset cycle; a new i_start yields bytes starting at 12.
REQ-040 Status reads 0x80 (bit 7 set, bit 6 clear) -> block stays in S_POLL with no write.
